db2_3_gen: RTL and testbench

Producer side of the bias-2_3 update interface: generates the delta bias db2_3 and the one-cycle select_update strobe consumed by the bias register.
- Accumulates BATCH backpropagated error terms delta2_3.
- Averages them, scales by the learning rate and negates (gradient descent).
- Saturates the result to 16-bit fixed point and issues it once per batch.
- Sits between the output-layer error unit and the bias-2_3 register in the training datapath.

---
 rtl/db2_3_gen_pkg.sv | 18 +
 rtl/fx_sat16.sv | 25 ++
 rtl/db2_3_gen.sv | 95 +++++++++
 tb/tb_db2_3_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/db2_3_gen_pkg.sv
// Shared constants for the bias/weight delta generators: Q6.10 fixed-point
// format, saturation limits and the common generator state encoding.
package db2_3_gen_pkg;

  // Q6.10 fixed-point format
  localparam int FX_FRAC = 10;
  localparam int DATA_W  = 16;

  localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;

  // Generator FSM encoding, shared by the db*/dw* generators
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] SCALE = 2'd2;
  localparam logic [1:0] ISSUE = 2'd3;

endpackage : db2_3_gen_pkg

// File: rtl/fx_sat16.sv
// Combinational saturation of a wide signed value to 16-bit Q6.10.
// The value fits exactly when every bit from the MSB down to bit 15 agrees.
module fx_sat16
  import db2_3_gen_pkg::*;
#(
  parameter int IN_W = 34
) (
  input  logic [IN_W-1:0]   din,
  output logic [DATA_W-1:0] dout
);

  logic [IN_W-DATA_W:0] hi;

  assign hi = din[IN_W-1:DATA_W-1];

  // Pass through when in range, otherwise clamp toward the sign of din
  always_comb begin
    // NOTE: dout gets a default first so every path assigns it and no latch is inferred.
    dout = din[DATA_W-1:0];
    if (!((&hi) || !(|hi))) begin
      dout = din[IN_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule : fx_sat16

// File: rtl/db2_3_gen.sv
// Delta-bias generator for bias 2_3: accumulates a batch of error terms,
// scales the sum by the learning rate, negates, saturates and issues the
// result with a one-cycle select_update strobe.
module db2_3_gen
  import db2_3_gen_pkg::*;
#(
  parameter int LOG2_BATCH = 2,
  parameter int FRAC       = FX_FRAC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] delta2_3,
  input  logic        delta_valid,
  input  logic [15:0] lr,
  output logic [15:0] db2_3,
  output logic        select_update,
  output logic        busy
);

  localparam int BATCH  = 1 << LOG2_BATCH;
  localparam int ACC_W  = DATA_W + LOG2_BATCH;
  localparam int PROD_W = 2 * DATA_W + LOG2_BATCH;
  localparam int CNT_W  = LOG2_BATCH + 1;
  // Dividing by BATCH (mean) and by 2^FRAC (product rescale) in one shift
  localparam int SHIFT  = FRAC + LOG2_BATCH;

  logic [1:0]               state;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         count;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] quot;
  logic signed [PROD_W-1:0] neg;
  logic [DATA_W-1:0]        sat_val;
  logic [DATA_W-1:0]        db_hold;

  // Floor shift first, then negate: -tiny rounds to +1 LSB, +tiny to 0
  assign quot = prod >>> SHIFT;
  assign neg  = -quot;

  fx_sat16 #(
    .IN_W (PROD_W)
  ) u_sat (
    .din  (neg),
    .dout (sat_val)
  );

  // FSM, accumulator, product register and held output value
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      count   <= '0;
      prod    <= '0;
      db_hold <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            count <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (start) begin
            acc   <= '0;
            count <= '0;
          end else if (delta_valid) begin
            acc   <= acc + ACC_W'($signed(delta2_3));
            count <= count + CNT_W'(1);
            if (count == CNT_W'(BATCH - 1)) begin
              state <= SCALE;
            end
          end
        end
        SCALE: begin
          prod  <= PROD_W'(acc) * PROD_W'($signed(lr));
          state <= ISSUE;
        end
        ISSUE: begin
          db_hold <= sat_val;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy          = (state != IDLE);
  assign select_update = (state == ISSUE);
  assign db2_3         = select_update ? sat_val : db_hold;

endmodule : db2_3_gen

// File: tb/tb_db2_3_gen.sv
// Self-checking bench for db2_3_gen: directed scenarios plus randomized
// batches compared against an arithmetic reference model.
module tb_db2_3_gen;

  localparam int LOG2_BATCH = 2;
  localparam int FRAC       = 10;
  localparam int BATCH      = 1 << LOG2_BATCH;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] delta2_3;
  logic        delta_valid;
  logic [15:0] lr;
  logic [15:0] db2_3;
  logic        select_update;
  logic        busy;

  int n_vec  = 0;
  int n_fail = 0;

  logic [15:0] prev_db;
  logic [15:0] samp_q[$];

  db2_3_gen #(
    .LOG2_BATCH (LOG2_BATCH),
    .FRAC       (FRAC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .delta2_3      (delta2_3),
    .delta_valid   (delta_valid),
    .lr            (lr),
    .db2_3         (db2_3),
    .select_update (select_update),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: mean of the batch times lr, floored to Q6.10, negated, clamped
  function automatic logic [15:0] model(input logic [15:0] lr_v);
    longint sum = 0;
    longint p, d, q, r;
    foreach (samp_q[i]) sum += longint'($signed(samp_q[i]));
    p = sum * longint'($signed(lr_v));
    d = longint'(1) << (FRAC + LOG2_BATCH);
    q = p / d;
    if ((p % d != 0) && (p < 0)) q = q - 1;
    r = -q;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  // Inputs change on the falling edge; outputs are sampled there too
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full batch from samp_q with optional random idle gaps, then the
  // SCALE / ISSUE / IDLE cycles are checked.
  task automatic run_batch(input string tag, input logic [15:0] lr_v, input bit gaps);
    logic [15:0] exp;
    exp   = model(lr_v);
    lr    = lr_v;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < samp_q.size(); i++) begin
      if (gaps) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          delta_valid = 1'b0;
          delta2_3    = 16'($urandom);
          step();
        end
      end
      delta_valid = 1'b1;
      delta2_3    = samp_q[i];
      step();
      if (i < samp_q.size() - 1) check({tag, " early strobe"}, 32'(select_update), 32'd0);
    end
    delta_valid = 1'b0;
    check({tag, " scale strobe"}, 32'(select_update), 32'd0);
    check({tag, " scale held"}, 32'(db2_3), 32'(prev_db));
    step();
    check({tag, " issue strobe"}, 32'(select_update), 32'd1);
    check({tag, " issue db"}, 32'(db2_3), 32'(exp));
    step();
    check({tag, " after strobe"}, 32'(select_update), 32'd0);
    check({tag, " after busy"}, 32'(busy), 32'd0);
    check({tag, " after db"}, 32'(db2_3), 32'(exp));
    prev_db = exp;
  endtask

  task automatic fill(input logic [15:0] first, input logic [15:0] rest);
    samp_q = {};
    samp_q.push_back(first);
    for (int i = 1; i < BATCH; i++) samp_q.push_back(rest);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    delta2_3    = '0;
    delta_valid = 1'b0;
    lr          = '0;
    prev_db     = '0;
    step();
    step();
    check("reset db", 32'(db2_3), 32'd0);
    check("reset strobe", 32'(select_update), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Nominal: mean 1.0 * 0.5 -> -0.5
    fill(16'h0400, 16'h0400);
    run_batch("nominal", 16'h0200, 1'b0);
    check("nominal value", 32'(prev_db), 32'h0000_FE00);

    // Saturation both directions
    fill(16'h8400, 16'h8400);
    run_batch("sat_pos", 16'h7C00, 1'b0);
    fill(16'h7C00, 16'h7C00);
    run_batch("sat_neg", 16'h7C00, 1'b0);

    // Rounding asymmetry
    fill(16'h0001, 16'h0000);
    run_batch("round_pos", 16'h0400, 1'b0);
    fill(16'hFFFF, 16'h0000);
    run_batch("round_neg", 16'h0400, 1'b0);

    // IDLE filtering and restart inside ACCUM
    for (int i = 0; i < 3; i++) begin
      delta_valid = 1'b1;
      delta2_3    = 16'h1234;
      step();
      check("idle busy", 32'(busy), 32'd0);
      check("idle strobe", 32'(select_update), 32'd0);
    end
    delta_valid = 1'b0;
    lr    = 16'h0400;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      delta_valid = 1'b1;
      delta2_3    = 16'h0400;
      step();
      check("pre-restart strobe", 32'(select_update), 32'd0);
    end
    delta_valid = 1'b1;
    delta2_3    = 16'h0400;
    fill(16'h0800, 16'h0800);
    // run_batch asserts start with delta_valid still high from above
    run_batch("restart", 16'h0400, 1'b0);
    check("restart value", 32'(prev_db), 32'h0000_F800);

    // Reset while in SCALE aborts the batch
    fill(16'h0400, 16'h0400);
    lr    = 16'h0400;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < BATCH; i++) begin
      delta_valid = 1'b1;
      delta2_3    = samp_q[i];
      step();
    end
    delta_valid = 1'b0;
    check("abort in scale busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort strobe", 32'(select_update), 32'd0);
    check("abort db", 32'(db2_3), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    step();
    check("abort no late strobe", 32'(select_update), 32'd0);
    prev_db = '0;
    run_batch("post_abort", 16'h0400, 1'b0);

    // Back-to-back batches: each run_batch starts the cycle after ISSUE
    fill(16'h0C00, 16'h0400);
    run_batch("b2b_first", 16'h0200, 1'b0);
    fill(16'hF000, 16'hFC00);
    run_batch("b2b_second", 16'h0300, 1'b0);

    // Randomized batches with idle gaps inside ACCUM
    for (int n = 0; n < 40; n++) begin
      samp_q = {};
      for (int i = 0; i < BATCH; i++) begin
        if ($urandom_range(0, 1) != 0) samp_q.push_back(16'($urandom));
        else samp_q.push_back(16'($signed(9'($urandom))));
      end
      if ($urandom_range(0, 1) != 0) run_batch("rand", 16'($urandom), 1'b1);
      else run_batch("rand_small", 16'($urandom_range(0, 16'h0800)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_db2_3_gen
